mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
- Sequences the shared external memory bus between two requesters inside the core: instruction fetch and data transfer (LDR/STR/SWP).
- Drives nMREQ, nRW, MAS and LOCK, the address-register source select, and the write-data bus enable.
- Absorbs nWAIT stretching, bus ABORT and a wait timeout.
- Returns per-requester completion pulses to armcontroller, and sits between armcontroller and the memory interface pins.

Parameters:
- FETCH_STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending; the next grant is then forced to fetch.
- WAIT_LIMIT, 255: consecutive nWAIT-low cycles that terminate an access with abort and timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- sysclk  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  fetch command offered.
- fetch_ready  out  1  fetch command accepted on this edge when fetch_valid is also high.
- fetch_done  out  1  one-cycle pulse: fetch finished.
- fetch_abort  out  1  qualifies fetch_done: fetch aborted.
- data_valid  in  1  data command offered.
- data_rw  in  1  1 = write, 0 = read; ignored when data_swp = 1.
- data_mas  in  2  transfer size: 00 byte, 01 half, 10 word.
- data_swp  in  1  atomic swap: locked read followed by write.
- data_ready  out  1  data command accepted on this edge when data_valid is also high.
- data_done  out  1  one-cycle pulse: data command finished (for SWP, after the write).
- data_abort  out  1  qualifies data_done: abort occurred.
- timeout  out  1  qualifies either done: termination was caused by WAIT_LIMIT.
- nWAIT  in  1  memory wait, active low.
- ABORT  in  1  memory abort; sampled only on a completing edge.
- nMREQ  out  1  memory request, active low.
- nRW  out  1  1 = write cycle.
- MAS  out  2  size of the current cycle.
- LOCK  out  1  atomic bus lock.
- AR_Bus_Sel  out  2  address source: 00 PC/fetch, 01 data address.
- WD_DBE  out  1  write-data bus enable.
- nSTALL  out  1  low while any valid is high without its ready.

Behaviour:
- States: IDLE, FETCH, DATA_RD, DATA_WR, SWP_RD, SWP_WR. All bus outputs are a Moore decode of the state and captured command registers.
- Reset values (asynchronous): state IDLE, nMREQ 1, nRW 0, MAS 10, LOCK 0, AR_Bus_Sel 00, WD_DBE 0, all done/abort/timeout 0, wait counter 0, starve counter 0.
- Access states: nMREQ 0.
  - FETCH: nRW 0, MAS 10, AR_Bus_Sel 00.
  - DATA_RD and SWP_RD: nRW 0, AR_Bus_Sel 01.
  - DATA_WR and SWP_WR: nRW 1, WD_DBE 1, AR_Bus_Sel 01.
  - Data states: MAS = captured data_mas.
  - LOCK is 1 in SWP_RD and SWP_WR only.
  - IDLE: nMREQ 1, WD_DBE 0; all other outputs hold their last values.
- Completing edge: a rising edge in an access state with nWAIT = 1, or with the wait counter at WAIT_LIMIT-1 and nWAIT = 0.
- Wait counter: increments on each nWAIT-low edge in an access state; clears on entry to any access state.
- Ready is combinational: asserted when state is IDLE, or in the cycle before a completing edge of FETCH, DATA_RD, DATA_WR or SWP_WR. This gives back-to-back accesses with zero idle cycles.
- Arbitration when both valids are high and ready applies:
  - Data wins, unless the starve counter equals FETCH_STARVE_LIMIT; then fetch wins.
  - Only one ready is high per cycle.
- Starve counter:
  - Increments on each data grant made while fetch_valid = 1.
  - Clears on a fetch grant, or when fetch_valid = 0.
  - Saturates at FETCH_STARVE_LIMIT.
- SWP_RD: ready is never asserted. The completing edge goes to SWP_WR with no idle cycle, and LOCK stays 1 across that boundary.
- Done pulses: done is 1 for exactly the one cycle after the completing edge. Abort/timeout flags are valid with done and 0 otherwise.
- ABORT sampled 1 on a completing edge sets the requester's abort flag.
  - If this happens in SWP_RD, SWP_WR is skipped and data_done with data_abort = 1 is issued.
  - LOCK drops on the same edge.
- Timeout completion: abort = 1 and timeout = 1; ABORT is ignored on that edge.
- RESET asserted mid-access: immediate return to reset values; no done is issued for the killed access.
- A command is captured only on a valid&ready edge. Command inputs are don't-care otherwise.

Decomposition:
- Shared package `mem_seq_pkg`:
  - State encoding constants.
  - MAS encodings (MAS_BYTE/HALF/WORD).
  - AR_Bus_Sel encodings (AR_SEL_PC, AR_SEL_DATA).
- One sub-module, `mem_wait_timer`: wait counter, completing-edge detect and timeout flag, parameterised by WAIT_LIMIT and CNT_W.
- Arbitration and FSM stay in the top module.

Test Plan:
- Single fetch, nWAIT = 1: fetch_valid at t0.
  - t0+1: nMREQ 0, nRW 0, MAS 10.
  - t0+2: fetch_done 1, fetch_abort 0, nMREQ 1.
- Word write with 3 wait cycles (data_rw 1, data_mas 10, nWAIT low for 3 edges):
  - nRW 1 and WD_DBE 1 for 4 cycles.
  - data_done on the 5th cycle after acceptance.
  - nSTALL low while data_valid is held against data_ready = 0.
- SWP: data_swp 1, data_mas 00.
  - SWP_RD then SWP_WR on consecutive cycles; LOCK 1 for both, MAS 00.
  - fetch_valid held throughout gets no ready until the SWP_WR completing cycle.
  - ABORT = 1 at the SWP_RD completion: no write cycle; data_done = 1 with data_abort = 1.
- Starvation, FETCH_STARVE_LIMIT = 4: both valids held high.
  - Grant order: D D D D F D D D D F.
  - No idle cycle between accesses.
- Timeout, WAIT_LIMIT = 5: nWAIT held 0 on a fetch.
  - fetch_done with fetch_abort = 1 and timeout = 1 exactly 6 cycles after acceptance.
  - ABORT is ignored.
- RESET pulse during DATA_WR wait: outputs return to reset values asynchronously, no data_done, and the next fetch proceeds normally.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, transfer sizes
// and address-register source selects.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DATA_RD = 3'd2,
    ST_DATA_WR = 3'd3,
    ST_SWP_RD  = 3'd4,
    ST_SWP_WR  = 3'd5
  } seq_state_t;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;

  localparam logic [1:0] AR_SEL_PC   = 2'b00;
  localparam logic [1:0] AR_SEL_DATA = 2'b01;

  function automatic logic is_write_state(seq_state_t s);
    return (s == ST_DATA_WR) || (s == ST_SWP_WR);
  endfunction

  function automatic logic is_locked_state(seq_state_t s);
    return (s == ST_SWP_RD) || (s == ST_SWP_WR);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester handshakes plus memory pin group of the sequencer.
// master: the sequencer itself; slave: requesters and memory around it.
interface mem_access_sequencer_if;

  logic       fetch_valid;
  logic       fetch_ready;
  logic       fetch_done;
  logic       fetch_abort;
  logic       data_valid;
  logic       data_rw;
  logic [1:0] data_mas;
  logic       data_swp;
  logic       data_ready;
  logic       data_done;
  logic       data_abort;
  logic       timeout;
  logic       nWAIT;
  logic       ABORT;
  logic       nMREQ;
  logic       nRW;
  logic [1:0] MAS;
  logic       LOCK;
  logic [1:0] AR_Bus_Sel;
  logic       WD_DBE;
  logic       nSTALL;

  modport master (
    input  fetch_valid, data_valid, data_rw, data_mas, data_swp, nWAIT, ABORT,
    output fetch_ready, fetch_done, fetch_abort, data_ready, data_done, data_abort,
           timeout, nMREQ, nRW, MAS, LOCK, AR_Bus_Sel, WD_DBE, nSTALL
  );

  modport slave (
    output fetch_valid, data_valid, data_rw, data_mas, data_swp, nWAIT, ABORT,
    input  fetch_ready, fetch_done, fetch_abort, data_ready, data_done, data_abort,
           timeout, nMREQ, nRW, MAS, LOCK, AR_Bus_Sel, WD_DBE, nSTALL
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts nWAIT-low cycles of the current access and flags the completing edge,
// either a normal one (nWAIT high) or a forced one at the wait limit.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic n_wait,
  output logic complete,
  output logic timed_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timed_out = active && !n_wait && (cnt_q == LAST);
  assign complete  = active && (n_wait || (cnt_q == LAST));

  // Clearing on every completion also covers back-to-back entry into the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (!active || complete)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates instruction fetch and data transfers onto the shared memory bus
// and returns per-requester completion pulses.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | bus released, either requester may be granted
//   ST_FETCH   | instruction fetch, word read from PC
//   ST_DATA_RD | data load
//   ST_DATA_WR | data store
//   ST_SWP_RD  | locked read half of a swap, never hands over
//   ST_SWP_WR  | locked write half of a swap
module mem_access_sequencer #(
  parameter int FETCH_STARVE_LIMIT = 4,
  parameter int WAIT_LIMIT         = 255,
  parameter int CNT_W              = 8
) (
  input logic                   sysclk,
  input logic                   RESET,
  mem_access_sequencer_if.master bus
);
  import mem_seq_pkg::*;

  localparam int STARVE_W = $clog2(FETCH_STARVE_LIMIT + 1);

  seq_state_t state_q, state_d;

  logic                access;
  logic                complete;
  logic                timed_out;
  logic                abort_hit;
  logic                accept_ok;
  logic                fetch_pick;
  logic                fetch_gnt;
  logic                data_gnt;
  logic                starve_full;
  logic [STARVE_W-1:0] starve_q;
  logic [1:0]          cmd_mas_q;
  logic [1:0]          mas_sel;
  logic                fetch_done_d, data_done_d;
  logic                fetch_done_q, fetch_abort_q;
  logic                data_done_q, data_abort_q, timeout_q;
  logic                nrw_q;
  logic [1:0]          mas_q;
  logic [1:0]          ar_sel_q;

  assign access = (state_q != ST_IDLE);

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk       (sysclk),
    .rst       (RESET),
    .active    (access),
    .n_wait    (bus.nWAIT),
    .complete  (complete),
    .timed_out (timed_out)
  );

  // A timeout always counts as an abort; the ABORT pin adds nothing on that edge.
  assign abort_hit   = timed_out || bus.ABORT;
  assign starve_full = (starve_q == STARVE_W'(FETCH_STARVE_LIMIT));
  assign accept_ok   = (state_q == ST_IDLE) || (complete && (state_q != ST_SWP_RD));
  assign fetch_pick  = bus.fetch_valid && (!bus.data_valid || starve_full);

  assign bus.fetch_ready = accept_ok && fetch_pick;
  assign bus.data_ready  = accept_ok && !fetch_pick;
  assign fetch_gnt       = bus.fetch_ready && bus.fetch_valid;
  assign data_gnt        = bus.data_ready && bus.data_valid;
  assign bus.nSTALL      = !((bus.fetch_valid && !bus.fetch_ready) ||
                             (bus.data_valid && !bus.data_ready));

  always_ff @(posedge sysclk or posedge RESET) begin
    if (RESET)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    if (state_q == ST_SWP_RD) begin
      if (complete)
        state_d = abort_hit ? ST_IDLE : ST_SWP_WR;
    end else if (accept_ok) begin
      state_d = ST_IDLE;
      if (fetch_gnt)
        state_d = ST_FETCH;
      else if (data_gnt)
        state_d = bus.data_swp ? ST_SWP_RD : (bus.data_rw ? ST_DATA_WR : ST_DATA_RD);
    end
    fetch_done_d = complete && (state_q == ST_FETCH);
    data_done_d  = complete && ((state_q inside {ST_DATA_RD, ST_DATA_WR, ST_SWP_WR}) ||
                                ((state_q == ST_SWP_RD) && abort_hit));
  end

  assign mas_sel = data_gnt ? bus.data_mas : cmd_mas_q;

  always_ff @(posedge sysclk or posedge RESET) begin
    if (RESET) begin
      fetch_done_q  <= 1'b0;
      fetch_abort_q <= 1'b0;
      data_done_q   <= 1'b0;
      data_abort_q  <= 1'b0;
      timeout_q     <= 1'b0;
      starve_q      <= '0;
      cmd_mas_q     <= MAS_WORD;
      nrw_q         <= 1'b0;
      mas_q         <= MAS_WORD;
      ar_sel_q      <= AR_SEL_PC;
    end else begin
      fetch_done_q  <= fetch_done_d;
      fetch_abort_q <= fetch_done_d && abort_hit;
      data_done_q   <= data_done_d;
      data_abort_q  <= data_done_d && abort_hit;
      timeout_q     <= (fetch_done_d || data_done_d) && timed_out;

      if (!bus.fetch_valid || fetch_gnt)
        starve_q <= '0;
      else if (data_gnt && !starve_full)
        starve_q <= starve_q + 1'b1;

      if (data_gnt)
        cmd_mas_q <= bus.data_mas;

      // Cycle attributes follow the state being entered and hold through IDLE.
      case (state_d)
        ST_FETCH: begin
          nrw_q    <= 1'b0;
          mas_q    <= MAS_WORD;
          ar_sel_q <= AR_SEL_PC;
        end
        ST_DATA_RD, ST_SWP_RD: begin
          nrw_q    <= 1'b0;
          mas_q    <= mas_sel;
          ar_sel_q <= AR_SEL_DATA;
        end
        ST_DATA_WR, ST_SWP_WR: begin
          nrw_q    <= 1'b1;
          mas_q    <= mas_sel;
          ar_sel_q <= AR_SEL_DATA;
        end
        default: ;
      endcase
    end
  end

  assign bus.nMREQ       = !access;
  assign bus.nRW         = nrw_q;
  assign bus.MAS         = mas_q;
  assign bus.LOCK        = is_locked_state(state_q);
  assign bus.AR_Bus_Sel  = ar_sel_q;
  assign bus.WD_DBE      = is_write_state(state_q);
  assign bus.fetch_done  = fetch_done_q;
  assign bus.fetch_abort = fetch_abort_q;
  assign bus.data_done   = data_done_q;
  assign bus.data_abort  = data_abort_q;
  assign bus.timeout     = timeout_q;

endmodule
